// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    // Which port owns the read data returning from memory in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    // Width of the fetch starvation counter; limits STARVE_LIMIT to 1..15.
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/unified_memory_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// Handshake: a requester raises *_req and holds its address/controls stable
// until the arbiter answers with *_gnt in the same cycle; the access is
// accepted on the rising edge that ends a cycle with *_gnt high. Read data
// comes back one cycle later, qualified by *_rvalid; *_rdata is meaningful
// only while the matching *_rvalid is high.
interface unified_memory_arbiter_if #(
    parameter int AW = 10
);
    import mem_arb_pkg::*;

    // Instruction-fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    // Data port
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    // Single-port memory
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic [3:0]    mem_write_byteenable;
    logic          mem_write_enable;
    logic [31:0]   mem_read_data;

    // Internal state made visible for observation
    logic [STARVE_CNT_W-1:0] starve_cnt;
    owner_e                  rd_owner;

    // Arbiter view
    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_read_data,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_address, mem_write_data, mem_write_byteenable, mem_write_enable,
        output starve_cnt, rd_owner
    );

    // Core plus memory view
    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_read_data,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_address, mem_write_data, mem_write_byteenable, mem_write_enable,
        input  starve_cnt, rd_owner
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive cycles the fetch port has been denied while requesting.
// Saturates at LIMIT; clears whenever fetch is granted or stops requesting.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    req,
    input  logic                    gnt,
    output logic [STARVE_CNT_W-1:0] cnt,
    output logic                    starving
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    // Saturating denial counter; only counts while arbitration is live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT_V)) begin
            cnt <= cnt + STARVE_CNT_W'(1);
        end
    end

    // Fetch must win the next contended cycle once the limit is reached.
    assign starving = (cnt == LIMIT_V);

endmodule

// File: rtl/unified_memory_arbiter.sv
// Shares one single-port, 1-clk-latency byte-enabled memory between the
// instruction-fetch and data ports. Data has priority; a starvation counter
// forces one fetch grant after STARVE_LIMIT consecutive denials.
module unified_memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    unified_memory_arbiter_if.slave  bus
);

    logic                    active;
    logic                    starving;
    logic                    d_win;
    logic                    i_win;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    owner_e                  rd_owner;

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr[31:AW+2], bus.i_addr[1:0],
                                bus.d_addr[31:AW+2], bus.d_addr[1:0]};

    // Grants are held off until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .en       (active),
        .req      (bus.i_req),
        .gnt      (i_win),
        .cnt      (starve_cnt),
        .starving (starving)
    );

    // Data wins unless fetch is starving and still asking; never both.
    assign d_win = active && bus.d_req && !(starving && bus.i_req);
    assign i_win = active && bus.i_req && !d_win;

    // Steer the memory port from the winner; idle cycles present the fetch address.
    always_comb begin
        bus.mem_address          = bus.i_addr[AW+1:2];
        bus.mem_write_data       = bus.d_wdata;
        bus.mem_write_enable     = 1'b0;
        bus.mem_write_byteenable = 4'b0000;
        if (d_win) begin
            bus.mem_address          = bus.d_addr[AW+1:2];
            bus.mem_write_enable     = bus.d_we;
            bus.mem_write_byteenable = bus.d_we ? bus.d_be : 4'b0000;
        end
    end

    // Remember who issued the read this cycle so the returning word is routed back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner <= OWN_NONE;
        end else if (i_win) begin
            rd_owner <= OWN_INSTR;
        end else if (d_win && !bus.d_we) begin
            rd_owner <= OWN_DATA;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    assign bus.i_gnt      = i_win;
    assign bus.d_gnt      = d_win;
    assign bus.i_rvalid   = (rd_owner == OWN_INSTR);
    assign bus.d_rvalid   = (rd_owner == OWN_DATA);
    assign bus.i_rdata    = bus.mem_read_data;
    assign bus.d_rdata    = bus.mem_read_data;
    assign bus.starve_cnt = starve_cnt;
    assign bus.rd_owner   = rd_owner;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for unified_memory_arbiter with a behavioural 1-clk memory.
module tb_unified_memory_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    unified_memory_arbiter_if #(.AW(AW)) bus ();

    unified_memory_arbiter #(
        .AW           (AW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory model: word k holds 0xC000_0000 | k, except word 8 which starts at 0.
    logic [31:0] mem [0:(1<<AW)-1];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < (1 << AW); k++) mem[k] <= 32'hC000_0000 | 32'(k);
            mem[8] <= 32'h0;
            loaded <= 1'b1;
        end else if (bus.mem_write_enable) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_write_byteenable[b])
                    mem[bus.mem_address][8*b +: 8] <= bus.mem_write_data[8*b +: 8];
        end
        bus.mem_read_data <= mem[bus.mem_address];
    end

    // Requester protocol: a denied request must be held unchanged into the next cycle.
    logic        i_pend = 1'b0;
    logic        d_pend = 1'b0;
    logic [31:0] i_addr_q, d_addr_q;
    always @(posedge clk) begin
        if (reset && i_pend && (!bus.i_req || bus.i_addr !== i_addr_q))
            $error("protocol: fetch request withdrawn or changed before grant");
        if (reset && d_pend && (!bus.d_req || bus.d_addr !== d_addr_q))
            $error("protocol: data request withdrawn or changed before grant");
        i_pend   <= reset && bus.i_req && !bus.i_gnt;
        d_pend   <= reset && bus.d_req && !bus.d_gnt;
        i_addr_q <= bus.i_addr;
        d_addr_q <= bus.d_addr;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0;
        bus.d_addr = 32'h20; bus.d_wdata = 32'h0;
        repeat (3) tick();
        checks++; if (bus.i_gnt !== 1'b0) begin failures++; $display("FAIL reset_i_gnt actual=%0h expected=0", bus.i_gnt); end
        checks++; if (bus.d_gnt !== 1'b0) begin failures++; $display("FAIL reset_d_gnt actual=%0h expected=0", bus.d_gnt); end
        checks++; if (bus.mem_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we actual=%0h expected=0", bus.mem_write_enable); end
        checks++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid actual=%0h%0h expected=00", bus.i_rvalid, bus.d_rvalid); end
        checks++; if (bus.starve_cnt !== 4'd0) begin failures++; $display("FAIL reset_starve actual=%0d expected=0", bus.starve_cnt); end
        // Release: no grant until the following edge.
        reset = 1'b1; bus.i_req = 1'b0;
        #1;
        checks++; if (bus.d_gnt !== 1'b0) begin failures++; $display("FAIL release_early_gnt actual=%0h expected=0", bus.d_gnt); end
        tick();
        checks++; if (bus.d_gnt !== 1'b1) begin failures++; $display("FAIL release_first_gnt actual=%0h expected=1", bus.d_gnt); end
        checks++; if (bus.mem_address !== 10'd8) begin failures++; $display("FAIL release_addr actual=%0h expected=8", bus.mem_address); end
        tick();
        bus.d_req = 1'b0;
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0) begin failures++; $display("FAIL release_read actual=%0h/%h expected=1/00000000", bus.d_rvalid, bus.d_rdata); end
        tick();
    endtask

    task automatic test_fetch();
        for (int k = 0; k < 3; k++) begin
            bus.i_req = 1'b1; bus.i_addr = 32'h10 + 32'(4 * k);
            #1;
            checks++; if (bus.i_gnt !== 1'b1 || bus.mem_address !== 10'(4 + k)) begin failures++; $display("FAIL fetch_gnt[%0d] actual=%0h/%0h expected=1/%0h", k, bus.i_gnt, bus.mem_address, 4 + k); end
            if (k > 0) begin
                checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== (32'hC000_0000 | 32'(3 + k))) begin failures++; $display("FAIL fetch_stream[%0d] actual=%0h/%h expected=1/%h", k, bus.i_rvalid, bus.i_rdata, 32'hC000_0000 | 32'(3 + k)); end
            end
            tick();
        end
        bus.i_req = 1'b0;
        checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hC000_0006) begin failures++; $display("FAIL fetch_last actual=%0h/%h expected=1/c0000006", bus.i_rvalid, bus.i_rdata); end
        tick();
        checks++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_idle actual=%0h%0h expected=00", bus.i_rvalid, bus.d_rvalid); end
    endtask

    task automatic test_write_read();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0101;
        bus.d_addr = 32'h20; bus.d_wdata = 32'hAABB_CCDD;
        #1;
        checks++; if (bus.d_gnt !== 1'b1 || bus.mem_write_enable !== 1'b1) begin failures++; $display("FAIL wr_gnt actual=%0h/%0h expected=1/1", bus.d_gnt, bus.mem_write_enable); end
        checks++; if (bus.mem_write_byteenable !== 4'b0101 || bus.mem_address !== 10'd8 || bus.mem_write_data !== 32'hAABB_CCDD) begin failures++; $display("FAIL wr_drive actual=%h/%0h/%h expected=5/8/aabbccdd", bus.mem_write_byteenable, bus.mem_address, bus.mem_write_data); end
        tick();
        bus.d_we = 1'b0;
        #1;
        checks++; if (bus.mem_write_enable !== 1'b0 || bus.mem_write_byteenable !== 4'b0000) begin failures++; $display("FAIL rd_drive actual=%0h/%h expected=0/0", bus.mem_write_enable, bus.mem_write_byteenable); end
        checks++; if (bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid actual=%0h expected=0", bus.d_rvalid); end
        tick();
        bus.d_req = 1'b0;
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h00BB_00DD || bus.i_rvalid !== 1'b0) begin failures++; $display("FAIL raw_read actual=%0h/%h/%0h expected=1/00bb00dd/0", bus.d_rvalid, bus.d_rdata, bus.i_rvalid); end
        tick();
    endtask

    task automatic test_starvation();
        bus.i_req = 1'b1; bus.i_addr = 32'h30;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (bus.i_gnt !== (c % 5 == 4) || bus.d_gnt !== (c % 5 != 4)) begin failures++; $display("FAIL starve_gnt[%0d] actual=i%0h/d%0h expected=i%0h/d%0h", c, bus.i_gnt, bus.d_gnt, c % 5 == 4, c % 5 != 4); end
            checks++; if (bus.starve_cnt !== 4'(c % 5)) begin failures++; $display("FAIL starve_cnt[%0d] actual=%0d expected=%0d", c, bus.starve_cnt, c % 5); end
            checks++; if (bus.d_rvalid !== (c > 0 && c % 5 != 0)) begin failures++; $display("FAIL starve_drv[%0d] actual=%0h expected=%0h", c, bus.d_rvalid, c > 0 && c % 5 != 0); end
            if (c == 5) begin
                checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hC000_000C) begin failures++; $display("FAIL starve_fetch actual=%0h/%h expected=1/c000000c", bus.i_rvalid, bus.i_rdata); end
            end
            tick();
        end
        bus.i_req = 1'b0;
        #1;
        checks++; if (bus.d_gnt !== 1'b1 || bus.starve_cnt !== 4'd0) begin failures++; $display("FAIL starve_resume actual=%0h/%0d expected=1/0", bus.d_gnt, bus.starve_cnt); end
        tick();
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        bus.i_req = 1'b1; bus.i_addr = 32'h44;
        #1;
        checks++; if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0 || bus.mem_address !== 10'd16) begin failures++; $display("FAIL cont_first actual=%0h/%0h/%0h expected=1/0/10", bus.d_gnt, bus.i_gnt, bus.mem_address); end
        tick();
        bus.d_req = 1'b0;
        #1;
        checks++; if (bus.i_gnt !== 1'b1 || bus.mem_address !== 10'd17) begin failures++; $display("FAIL cont_second actual=%0h/%0h expected=1/11", bus.i_gnt, bus.mem_address); end
        checks++; if (bus.d_rvalid !== 1'b1 || bus.i_rvalid !== 1'b0 || bus.d_rdata !== 32'hC000_0010) begin failures++; $display("FAIL cont_dret actual=%0h/%0h/%h expected=1/0/c0000010", bus.d_rvalid, bus.i_rvalid, bus.d_rdata); end
        tick();
        bus.i_req = 1'b0;
        checks++; if (bus.i_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.i_rdata !== 32'hC000_0011) begin failures++; $display("FAIL cont_iret actual=%0h/%0h/%h expected=1/0/c0000011", bus.i_rvalid, bus.d_rvalid, bus.i_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        bus.i_req = 1'b1; bus.i_addr = 32'h50;
        #1;
        checks++; if (bus.i_gnt !== 1'b1) begin failures++; $display("FAIL mid_gnt actual=%0h expected=1", bus.i_gnt); end
        tick();
        reset = 1'b0; bus.d_req = 1'b1;
        #1;
        checks++; if (bus.i_rvalid !== 1'b0 || bus.rd_owner !== OWN_NONE) begin failures++; $display("FAIL mid_drop actual=%0h/%0d expected=0/0", bus.i_rvalid, bus.rd_owner); end
        checks++; if (bus.i_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin failures++; $display("FAIL mid_gated actual=%0h/%0h expected=0/0", bus.i_gnt, bus.d_gnt); end
        repeat (2) tick();
        checks++; if (bus.starve_cnt !== 4'd0 || bus.i_rvalid !== 1'b0) begin failures++; $display("FAIL mid_hold actual=%0d/%0h expected=0/0", bus.starve_cnt, bus.i_rvalid); end
        reset = 1'b1; bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick();
        checks++; if (bus.starve_cnt !== 4'd0 || bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL mid_release actual=%0d/%0h/%0h expected=0/0/0", bus.starve_cnt, bus.i_rvalid, bus.d_rvalid); end
        tick();
        checks++; if (bus.i_rvalid !== 1'b0) begin failures++; $display("FAIL mid_no_replay actual=%0h expected=0", bus.i_rvalid); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_fetch();
        test_write_read();
        test_starvation();
        test_contention();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
